// File: rtl/mig_readback_engine.sv
// mig_readback_engine: issues MIG read commands over a contiguous region of
// capture RAM and returns the read data as a 256-bit stream with backpressure.
// MIG read data cannot be stalled. A command is only presented when the buffer
// has room for its whole burst, counting every burst still in flight.
module mig_readback_engine #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_STEP  = 8
) (
    input  logic         clk_ram,
    input  logic         rst,
    input  logic         req_en,
    input  logic [28:0]  req_addr,
    input  logic [15:0]  req_count,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [28:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    input  logic [255:0] app_rd_data,
    input  logic         app_rd_data_end,
    input  logic         app_rd_data_valid,
    output logic         rd_valid,
    output logic [255:0] rd_data,
    output logic         rd_last,
    input  logic         rd_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;   // fifo occupancy / outstanding bursts, 0..DEPTH
    localparam int UW = AW + 3;   // headroom for occupancy + 2*outstanding + 2

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t         state_q;
    logic           busy_q, done_q, overflow_q, app_en_q;
    logic [28:0]    app_addr_q;
    logic [15:0]    req_cnt_q, cmds_q, cmds_d;
    logic [16:0]    pops_q, last_idx;
    logic [CW-1:0]  outs_q, outs_d, fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]  used_d;
    logic [255:0]   mem_q [FIFO_DEPTH];

    logic accept, pop, push, drop, burst_done, has_out, fifo_full;
    logic credit_ok, last_pop;

    assign accept     = app_en_q & app_rdy;
    assign rd_valid   = (fifo_cnt_q != '0);
    assign pop        = rd_valid & rd_ready;
    assign has_out    = (outs_q != '0);
    assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    // Data with no outstanding command, or with no room left, is discarded.
    assign push       = app_rd_data_valid & has_out & ~fifo_full;
    assign drop       = app_rd_data_valid & (~has_out | fifo_full);
    assign burst_done = app_rd_data_valid & app_rd_data_end & has_out;

    assign last_idx = {req_cnt_q, 1'b0} - 17'd1;
    assign last_pop = pop & (pops_q == last_idx);

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign app_en   = app_en_q;
    assign app_addr = app_addr_q;
    assign app_cmd  = 3'b001;
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_last  = rd_valid & busy_q & (pops_q == last_idx);

    // Next-state bookkeeping and the credit check for the command presented next cycle.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        outs_d     = outs_q + CW'(accept) - CW'(burst_done);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        cmds_d     = cmds_q + 16'(accept);
        used_d     = UW'(fifo_cnt_d) + (UW'(outs_d) << 1);
        credit_ok  = (used_d + UW'(2)) <= UW'(FIFO_DEPTH);
    end

    // Read-data buffer storage; emptied by pointer reset, contents need no reset.
    always_ff @(posedge clk_ram) begin
        if (push) mem_q[wr_ptr_q] <= app_rd_data;
    end

    // Request FSM, command issue, buffer pointers and status flags.
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            app_en_q   <= 1'b0;
            app_addr_q <= '0;
            req_cnt_q  <= '0;
            cmds_q     <= '0;
            pops_q     <= '0;
            outs_q     <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            outs_q     <= outs_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            if (pop)  pops_q <= pops_q + 17'd1;
            case (state_q)
                IDLE: begin
                    app_en_q <= 1'b0;
                    if (req_en) begin
                        if (req_count != '0) begin
                            state_q    <= ISSUE;
                            busy_q     <= 1'b1;
                            app_addr_q <= req_addr;
                            req_cnt_q  <= req_count;
                            cmds_q     <= '0;
                            pops_q     <= '0;
                            app_en_q   <= credit_ok;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cmds_q <= cmds_d;
                    if (accept) app_addr_q <= app_addr_q + 29'(ADDR_STEP);
                    // A stalled command keeps its slot; otherwise re-evaluate credit.
                    if (!(app_en_q && !app_rdy))
                        app_en_q <= (cmds_d < req_cnt_q) && credit_ok;
                    if (cmds_d == req_cnt_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (last_pop) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_readback_engine.sv
// Bench for mig_readback_engine: a randomised MIG model plus a stream scoreboard.
module tb_mig_readback_engine;
    localparam int DEPTH = 8;

    logic clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    logic         rst, req_en, busy, done, overflow, app_en, app_rdy;
    logic [28:0]  req_addr, app_addr;
    logic [15:0]  req_count;
    logic [2:0]   app_cmd;
    logic [255:0] app_rd_data, rd_data;
    logic         app_rd_data_end, app_rd_data_valid, rd_valid, rd_last, rd_ready;

    mig_readback_engine #(.FIFO_DEPTH(DEPTH), .ADDR_STEP(8)) dut (
        .clk_ram(clk_ram), .rst(rst), .req_en(req_en), .req_addr(req_addr),
        .req_count(req_count), .busy(busy), .done(done), .overflow(overflow),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_ready(rd_ready)
    );

    typedef struct {logic [28:0] a; bit b; int due;} beat_t;
    beat_t rdq[$];

    int cyc = 0;
    always @(posedge clk_ram) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int rdy_pct = 100, rr_pct = 100;
    bit rdy_script[$];
    bit inject_stray = 0;
    logic [28:0]  cmd_log[$];
    int           cmd_cyc[$];
    logic [255:0] beat_log[$];
    bit           last_log[$];
    int           pop_cyc[$];
    int           done_cyc[$];
    int first_en = -1, hold_err = 0, mock_out = 0, max_out = 0, last_due = 0, busy_seen = 0;
    bit prev_stall = 0;
    logic [28:0] prev_addr = '0;

    logic [28:0]  exp_addr[$];
    logic [255:0] exp_beat[$];

    function automatic logic [255:0] beat_data(input logic [28:0] a, input bit b);
        logic [2:0] bb;
        bb = {2'b00, b};
        return {a, bb, {7{a ^ {29{b}}}}, 21'h15A5A5};
    endfunction

    // Reference: n bursts at a0, a0+8, ... (29-bit wrap), two beats each.
    function automatic void build_model(input logic [28:0] a0, input int n);
        exp_addr.delete();
        exp_beat.delete();
        for (int i = 0; i < n; i++) begin
            logic [28:0] a;
            a = a0 + 29'(i * 8);
            exp_addr.push_back(a);
            exp_beat.push_back(beat_data(a, 1'b0));
            exp_beat.push_back(beat_data(a, 1'b1));
        end
    endfunction

    // MIG model and observer: drives inputs on the falling edge for the next rising edge.
    always @(negedge clk_ram) begin : mock
        int d;
        beat_t t;
        if (rst) begin
            rdq.delete();
            mock_out = 0;
            last_due = 0;
            prev_stall = 0;
            app_rd_data_valid = 1'b0;
            app_rd_data_end = 1'b0;
        end else begin
            if (prev_stall && (app_en !== 1'b1 || app_addr !== prev_addr)) hold_err++;
            if (rdy_script.size() > 0) app_rdy = rdy_script.pop_front();
            else app_rdy = ($urandom_range(99) < rdy_pct);
            rd_ready = ($urandom_range(99) < rr_pct);
            prev_stall = app_en && !app_rdy;
            prev_addr = app_addr;
            if (app_en && first_en < 0) first_en = cyc;
            if (busy) busy_seen++;
            if (done) done_cyc.push_back(cyc);
            if (app_en && app_rdy) begin
                cmd_log.push_back(app_addr);
                cmd_cyc.push_back(cyc);
                d = cyc + $urandom_range(2, 6);
                if (d <= last_due) d = last_due + 1;
                rdq.push_back('{app_addr, 1'b0, d});
                rdq.push_back('{app_addr, 1'b1, d + 1});
                last_due = d + 1;
                mock_out++;
                if (mock_out > max_out) max_out = mock_out;
            end
            if (rd_valid && rd_ready) begin
                beat_log.push_back(rd_data);
                last_log.push_back(rd_last);
                pop_cyc.push_back(cyc);
            end
            if (inject_stray) begin
                app_rd_data_valid = 1'b1;
                app_rd_data_end = 1'b1;
                app_rd_data = {8{$urandom}};
                inject_stray = 0;
            end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                t = rdq.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data_end = t.b;
                app_rd_data = beat_data(t.a, t.b);
                if (t.b) mock_out--;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data_end = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        cmd_log.delete(); cmd_cyc.delete(); beat_log.delete(); last_log.delete();
        pop_cyc.delete(); done_cyc.delete();
        first_en = -1; busy_seen = 0; max_out = 0;
    endtask

    task automatic start_req(input logic [28:0] a, input logic [15:0] n, input bit stall, output int rc);
        @(posedge clk_ram); #1;
        if (stall) rdy_script = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        req_addr = a; req_count = n; req_en = 1'b1; rc = cyc;
        @(posedge clk_ram); #1;
        req_en = 1'b0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_ram); #1;
            if (done_cyc.size() > 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_ram); #1;
        total++;
        if ({busy, done, overflow, app_en, app_addr, app_cmd, rd_valid, rd_last} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 29'h0, 3'b001, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got busy=%b done=%b ovf=%b en=%b addr=%h cmd=%b v=%b last=%b want 0 0 0 0 0 001 0 0",
                     busy, done, overflow, app_en, app_addr, app_cmd, rd_valid, rd_last);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk_ram); #1;
    endtask

    task automatic test_basic();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 100;
        build_model(29'h100, 4);
        start_req(29'h100, 16'd4, 1'b0, rc);
        wait_done(500, ok);
        repeat (3) @(posedge clk_ram); #1;
        total++; if (!ok) begin bad++; $display("FAIL basic_done: got no done want done"); end
        total++; if (cmd_log.size() != 4) begin bad++; $display("FAIL basic_ncmd: got %0d want 4", cmd_log.size()); end
        for (int i = 0; i < cmd_log.size() && i < 4; i++) begin
            total++; if (cmd_log[i] !== exp_addr[i]) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, cmd_log[i], exp_addr[i]); end
        end
        total++; if (app_cmd !== 3'b001) begin bad++; $display("FAIL basic_cmd: got %b want 001", app_cmd); end
        if (cmd_cyc.size() == 4) begin
            total++; if (cmd_cyc[0] != rc + 1) begin bad++; $display("FAIL basic_first_en: got cycle %0d want %0d", cmd_cyc[0], rc + 1); end
            total++; if (cmd_cyc[3] != cmd_cyc[0] + 3) begin bad++; $display("FAIL basic_b2b: got cycle %0d want %0d", cmd_cyc[3], cmd_cyc[0] + 3); end
        end
        total++; if (beat_log.size() != 8) begin bad++; $display("FAIL basic_nbeats: got %0d want 8", beat_log.size()); end
        for (int i = 0; i < beat_log.size() && i < 8; i++) begin
            total++; if (beat_log[i] !== exp_beat[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, beat_log[i], exp_beat[i]); end
            total++; if (last_log[i] !== (i == 7)) begin bad++; $display("FAIL basic_last[%0d]: got %b want %b", i, last_log[i], i == 7); end
        end
        if (pop_cyc.size() == 8 && done_cyc.size() > 0) begin
            total++; if (done_cyc[0] != pop_cyc[7] + 1) begin bad++; $display("FAIL basic_done_lat: got cycle %0d want %0d", done_cyc[0], pop_cyc[7] + 1); end
        end
        total++; if (busy !== 1'b0 || done_cyc.size() != 1) begin bad++; $display("FAIL basic_idle: got busy=%b dones=%0d want 0 1", busy, done_cyc.size()); end
    endtask

    task automatic test_stall();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 100; hold_err = 0;
        build_model(29'h2000, 4);
        start_req(29'h2000, 16'd4, 1'b1, rc);
        wait_done(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_done: got no done want done"); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL stall_hold: got %0d violations want 0", hold_err); end
        total++; if (cmd_log.size() != 4) begin bad++; $display("FAIL stall_ncmd: got %0d want 4", cmd_log.size()); end
        for (int i = 0; i < cmd_log.size() && i < 4; i++) begin
            total++; if (cmd_log[i] !== exp_addr[i]) begin bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, cmd_log[i], exp_addr[i]); end
        end
        if (cmd_cyc.size() >= 2) begin
            total++; if (cmd_cyc[1] != cmd_cyc[0] + 3) begin bad++; $display("FAIL stall_gap: got cycle %0d want %0d", cmd_cyc[1], cmd_cyc[0] + 3); end
        end
        total++; if (beat_log.size() != 8) begin bad++; $display("FAIL stall_nbeats: got %0d want 8", beat_log.size()); end
    endtask

    task automatic test_backpressure();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 0;
        build_model(29'h4000, 10);
        start_req(29'h4000, 16'd10, 1'b0, rc);
        repeat (60) @(posedge clk_ram); #1;
        total++; if (cmd_log.size() != 4) begin bad++; $display("FAIL bp_stop: got %0d cmds want 4", cmd_log.size()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_hold: got %b want 0", overflow); end
        rr_pct = 100;
        wait_done(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_done: got no done want done"); end
        total++; if (cmd_log.size() != 10) begin bad++; $display("FAIL bp_ncmd: got %0d want 10", cmd_log.size()); end
        for (int i = 0; i < cmd_log.size() && i < 10; i++) begin
            total++; if (cmd_log[i] !== exp_addr[i]) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, cmd_log[i], exp_addr[i]); end
        end
        if (cmd_cyc.size() >= 5 && pop_cyc.size() >= 2) begin
            total++; if (cmd_cyc[4] <= pop_cyc[1]) begin bad++; $display("FAIL bp_resume: got cycle %0d want after %0d", cmd_cyc[4], pop_cyc[1]); end
        end
        total++; if (beat_log.size() != 20) begin bad++; $display("FAIL bp_nbeats: got %0d want 20", beat_log.size()); end
        for (int i = 0; i < beat_log.size() && i < 20; i++) begin
            total++; if (beat_log[i] !== exp_beat[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, beat_log[i], exp_beat[i]); end
        end
        total++; if (overflow !== 1'b0 || max_out > DEPTH / 2) begin bad++; $display("FAIL bp_credit: got ovf=%b max_out=%0d want 0 <=%0d", overflow, max_out, DEPTH / 2); end
    endtask

    task automatic test_wrap();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 100;
        build_model(29'h1FFFFFF8, 2);
        start_req(29'h1FFFFFF8, 16'd2, 1'b0, rc);
        wait_done(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_done: got no done want done"); end
        total++; if (cmd_log.size() != 2) begin bad++; $display("FAIL wrap_ncmd: got %0d want 2", cmd_log.size()); end
        else begin
            total++; if (cmd_log[0] !== 29'h1FFFFFF8) begin bad++; $display("FAIL wrap_a0: got %h want 1ffffff8", cmd_log[0]); end
            total++; if (cmd_log[1] !== 29'h0) begin bad++; $display("FAIL wrap_a1: got %h want 0", cmd_log[1]); end
        end
        for (int i = 0; i < beat_log.size() && i < 4; i++) begin
            total++; if (beat_log[i] !== exp_beat[i]) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, beat_log[i], exp_beat[i]); end
        end
    endtask

    task automatic test_zero_count();
        int rc;
        clear_logs();
        start_req(29'h500, 16'd0, 1'b0, rc);
        repeat (5) @(posedge clk_ram); #1;
        total++; if (done_cyc.size() != 1 || done_cyc[0] != rc + 1) begin bad++; $display("FAIL zero_done: got %0d pulses first %0d want 1 at %0d", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, rc + 1); end
        total++; if (first_en != -1 || busy_seen != 0) begin bad++; $display("FAIL zero_quiet: got en_cycle=%0d busy_cycles=%0d want -1 0", first_en, busy_seen); end
    endtask

    task automatic test_busy_ignore();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 50;
        build_model(29'h600, 3);
        start_req(29'h600, 16'd3, 1'b0, rc);
        @(posedge clk_ram); #1;
        req_addr = 29'h7000; req_count = 16'd5; req_en = 1'b1;
        @(posedge clk_ram); #1;
        req_en = 1'b0;
        wait_done(500, ok);
        repeat (8) @(posedge clk_ram); #1;
        total++; if (!ok) begin bad++; $display("FAIL busy_done: got no done want done"); end
        total++; if (cmd_log.size() != 3 || beat_log.size() != 6 || done_cyc.size() != 1) begin bad++; $display("FAIL busy_ignore: got cmds=%0d beats=%0d dones=%0d want 3 6 1", cmd_log.size(), beat_log.size(), done_cyc.size()); end
        for (int i = 0; i < cmd_log.size() && i < 3; i++) begin
            total++; if (cmd_log[i] !== exp_addr[i]) begin bad++; $display("FAIL busy_addr[%0d]: got %h want %h", i, cmd_log[i], exp_addr[i]); end
        end
        rr_pct = 100;
    endtask

    task automatic test_stray();
        clear_logs();
        @(posedge clk_ram); #1;
        inject_stray = 1;
        repeat (3) @(posedge clk_ram); #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL stray_set: got %b want 1", overflow); end
        repeat (10) @(posedge clk_ram); #1;
        total++; if (overflow !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL stray_sticky: got ovf=%b v=%b want 1 0", overflow, rd_valid); end
        rst = 1'b1;
        @(posedge clk_ram); #1;
        rst = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stray_clear: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int rc; bit ok;
        clear_logs(); rdy_pct = 100; rr_pct = 0;
        start_req(29'h8000, 16'd6, 1'b0, rc);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_log.size() >= 2) begin ok = 1; break; end
            @(posedge clk_ram); #1;
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_issue: got %0d cmds want 2", cmd_log.size()); end
        rst = 1'b1;
        @(posedge clk_ram); #1;
        total++;
        if ({busy, done, overflow, app_en, app_addr, app_cmd, rd_valid, rd_last} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 29'h0, 3'b001, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_values: got busy=%b done=%b ovf=%b en=%b addr=%h cmd=%b v=%b last=%b want 0 0 0 0 0 001 0 0",
                     busy, done, overflow, app_en, app_addr, app_cmd, rd_valid, rd_last);
        end
        rst = 1'b0;
        clear_logs(); rr_pct = 100;
        build_model(29'h9000, 1);
        start_req(29'h9000, 16'd1, 1'b0, rc);
        wait_done(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_after_done: got no done want done"); end
        total++; if (cmd_log.size() != 1 || beat_log.size() != 2) begin bad++; $display("FAIL rstmid_after_n: got cmds=%0d beats=%0d want 1 2", cmd_log.size(), beat_log.size()); end
        else begin
            total++; if (cmd_log[0] !== 29'h9000 || beat_log[0] !== exp_beat[0] || beat_log[1] !== exp_beat[1] || last_log[1] !== 1'b1)
                begin bad++; $display("FAIL rstmid_after_data: got addr=%h last=%b want 9000 1", cmd_log[0], last_log[1]); end
        end
    endtask

    task automatic test_random();
        int rc, n; bit ok;
        logic [28:0] a;
        for (int r = 0; r < 6; r++) begin
            clear_logs(); hold_err = 0;
            a = 29'($urandom);
            if (r == 0) a = 29'h1FFFFFE0;
            n = $urandom_range(1, 12);
            rdy_pct = $urandom_range(40, 100);
            rr_pct = $urandom_range(20, 100);
            build_model(a, n);
            start_req(a, 16'(n), 1'b0, rc);
            wait_done(3000, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done: got no done want done", r); end
            total++; if (cmd_log.size() != n || beat_log.size() != 2 * n) begin bad++; $display("FAIL rnd%0d_counts: got cmds=%0d beats=%0d want %0d %0d", r, cmd_log.size(), beat_log.size(), n, 2 * n); end
            for (int i = 0; i < cmd_log.size() && i < n; i++) begin
                total++; if (cmd_log[i] !== exp_addr[i]) begin bad++; $display("FAIL rnd%0d_addr[%0d]: got %h want %h", r, i, cmd_log[i], exp_addr[i]); end
            end
            for (int i = 0; i < beat_log.size() && i < 2 * n; i++) begin
                total++; if (beat_log[i] !== exp_beat[i] || last_log[i] !== (i == 2 * n - 1)) begin bad++; $display("FAIL rnd%0d_beat[%0d]: got %h last=%b want %h last=%b", r, i, beat_log[i], last_log[i], exp_beat[i], i == 2 * n - 1); end
            end
            if (done_cyc.size() > 0 && pop_cyc.size() > 0) begin
                total++; if (done_cyc[0] != pop_cyc[pop_cyc.size() - 1] + 1) begin bad++; $display("FAIL rnd%0d_done_lat: got %0d want %0d", r, done_cyc[0], pop_cyc[pop_cyc.size() - 1] + 1); end
            end
            total++; if (hold_err != 0 || overflow !== 1'b0 || max_out > DEPTH / 2) begin bad++; $display("FAIL rnd%0d_proto: got hold=%0d ovf=%b max_out=%0d want 0 0 <=%0d", r, hold_err, overflow, max_out, DEPTH / 2); end
            repeat (2) @(posedge clk_ram); #1;
        end
        rdy_pct = 100; rr_pct = 100;
    endtask

    initial begin
        rst = 1'b1; req_en = 1'b0; req_addr = '0; req_count = '0;
        app_rdy = 1'b0; app_rd_data = '0; app_rd_data_end = 1'b0;
        app_rd_data_valid = 1'b0; rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_busy_ignore();
        test_stray();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
